// File: rtl/draw_port_arbiter.sv
// ---------------------------------------------------------------------------
// draw_port_arbiter
//
// Shares the single VGA adapter write port between NREQ rectangle-draw
// requesters (stage painter, Mario draw, Mario erase, enemy draw). One
// requester is chosen round-robin and its rectangle is walked pixel by pixel
// (x inner, y outer). Each pixel lands on the adapter one cycle after its
// offset is presented, which is when the requester's synchronous colour ROM
// answers on pix_colour.
//
// Optional build macro: DRAW_ARB_TRANSPARENT_EN
//   defined   : pixels whose pix_colour equals TRANSP_COLOUR are not written
//               (x/y/colour still update, sequencing and timing unchanged)
//   undefined : every on-screen pixel is written
//
// Ports
//   clk, reset   system clock; asynchronous active-high reset
//   req          per-requester level request, held until its done pulse
//   req_x/req_y  packed rectangle origins, slot i at [i*W +: W]
//   req_w/req_h  packed rectangle size in pixels (0 = empty job)
//   pix_colour   granted requester's colour, valid one cycle after offsets
//   gnt          one-hot grant, stable from LOAD through FLUSH
//   offs_x/offs_y pixel offset within the rectangle (colour ROM address)
//   x, y, colour, writeEn  VGA adapter write port
//   done         one-cycle completion pulse to the winner
//   busy         high whenever a job is in progress
// ---------------------------------------------------------------------------
module draw_port_arbiter #(
   parameter int            NREQ          = 4,
   parameter int            XW            = 8,
   parameter int            YW            = 7,
   parameter int            CW            = 3,
   parameter int            SCREEN_W      = 160,
   parameter int            SCREEN_H      = 120,
   parameter logic [CW-1:0] TRANSP_COLOUR = 3'b000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*XW-1:0]   req_x,
   input  logic [NREQ*YW-1:0]   req_y,
   input  logic [NREQ*XW-1:0]   req_w,
   input  logic [NREQ*YW-1:0]   req_h,
   input  logic [CW-1:0]        pix_colour,
   output logic [NREQ-1:0]      gnt,
   output logic [XW-1:0]        offs_x,
   output logic [YW-1:0]        offs_y,
   output logic [XW-1:0]        x,
   output logic [YW-1:0]        y,
   output logic [CW-1:0]        colour,
   output logic                 writeEn,
   output logic [NREQ-1:0]      done,
   output logic                 busy
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int XSW = XW + 1;
   localparam int YSW = YW + 1;

   localparam logic [PW-1:0]  LAST_REQ = PW'(NREQ - 1);
   localparam logic [XSW-1:0] XLIM     = XSW'(SCREEN_W);
   localparam logic [YSW-1:0] YLIM     = YSW'(SCREEN_H);

`ifdef DRAW_ARB_TRANSPARENT_EN
   localparam logic TRANSP_EN = 1'b1;
`else
   localparam logic TRANSP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAW,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   // arbitration
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   scan;
   logic            found;
   logic [NREQ-1:0] win_oh;

   // per-slot geometry views of the packed request buses
   logic [XW-1:0] slot_x [NREQ];
   logic [YW-1:0] slot_y [NREQ];
   logic [XW-1:0] slot_w [NREQ];
   logic [YW-1:0] slot_h [NREQ];

   // latched job geometry and offset walker
   logic [XW-1:0] lat_x;
   logic [YW-1:0] lat_y;
   logic [XW-1:0] lat_w;
   logic [YW-1:0] lat_h;
   logic [XW-1:0] ox;
   logic [YW-1:0] oy;
   logic          row_end;
   logic          last_pix;

   // write pipeline
   logic [XSW-1:0] sum_x;
   logic [YSW-1:0] sum_y;
   logic           pend;
   logic           on_screen;
   logic [XW-1:0]  x_r;
   logic [YW-1:0]  y_r;
   logic [CW-1:0]  colour_hold;

   // ------------------------------------------------------------------------
   // Unpack request geometry
   // ------------------------------------------------------------------------
   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         slot_x[k] = req_x[k*XW +: XW];
         slot_y[k] = req_y[k*YW +: YW];
         slot_w[k] = req_w[k*XW +: XW];
         slot_h[k] = req_h[k*YW +: YW];
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin pick: first set request scanning upward from rr_ptr, wrapping
   // ------------------------------------------------------------------------
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      scan  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan = PW'((32'(rr_ptr) + k) % NREQ);
         if (!found && req[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
      end
   end

   always_comb begin
      win_oh      = '0;
      win_oh[win] = 1'b1;
   end

   assign row_end  = (ox == lat_w - 1'b1);
   assign last_pix = row_end && (oy == lat_h - 1'b1);

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = ((lat_w == '0) || (lat_h == '0)) ? S_DONE : S_DRAW;
         S_DRAW:  if (last_pix) state_nxt = S_FLUSH;
         S_FLUSH: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Job latch, offset walker, round-robin pointer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
         win    <= '0;
         lat_x  <= '0;
         lat_y  <= '0;
         lat_w  <= '0;
         lat_h  <= '0;
         ox     <= '0;
         oy     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  win   <= pick;
                  lat_x <= slot_x[pick];
                  lat_y <= slot_y[pick];
                  lat_w <= slot_w[pick];
                  lat_h <= slot_h[pick];
                  ox    <= '0;
                  oy    <= '0;
               end
            end
            S_DRAW: begin
               if (last_pix) begin
                  ox <= '0;
                  oy <= '0;
               end else if (row_end) begin
                  ox <= '0;
                  oy <= oy + 1'b1;
               end else begin
                  ox <= ox + 1'b1;
               end
            end
            S_DONE: begin
               rr_ptr <= (win == LAST_REQ) ? '0 : win + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Write pipeline: address computed from the offset presented this cycle,
   // written next cycle alongside the ROM's colour. Sums carry one extra bit
   // so a wrap past the coordinate width is clipped rather than aliased.
   // ------------------------------------------------------------------------
   assign sum_x = {1'b0, lat_x} + {1'b0, ox};
   assign sum_y = {1'b0, lat_y} + {1'b0, oy};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend        <= 1'b0;
         on_screen   <= 1'b0;
         x_r         <= '0;
         y_r         <= '0;
         colour_hold <= '0;
      end else begin
         pend <= (state == S_DRAW);
         if (state == S_DRAW) begin
            x_r       <= sum_x[XW-1:0];
            y_r       <= sum_y[YW-1:0];
            on_screen <= (sum_x < XLIM) && (sum_y < YLIM);
         end
         if (pend) begin
            colour_hold <= pix_colour;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // colour follows the ROM directly in the write cycle; the last written
   // colour is held afterwards so the adapter bus does not chatter.
   assign colour  = pend ? pix_colour : colour_hold;
   assign writeEn = pend && on_screen && !(TRANSP_EN && (pix_colour == TRANSP_COLOUR));
   assign x       = x_r;
   assign y       = y_r;
   assign offs_x  = ox;
   assign offs_y  = oy;
   assign busy    = (state != S_IDLE);
   assign gnt     = ((state == S_LOAD) || (state == S_DRAW) || (state == S_FLUSH)) ? win_oh : '0;
   assign done    = (state == S_DONE) ? win_oh : '0;

endmodule

// File: tb/tb_draw_port_arbiter.sv
`timescale 1ns/1ps
module tb_draw_port_arbiter;

   localparam int NREQ = 4;
   localparam int XW   = 8;
   localparam int YW   = 7;
   localparam int CW   = 3;

`ifdef DRAW_ARB_TRANSPARENT_EN
   localparam bit TR = 1'b1;
`else
   localparam bit TR = 1'b0;
`endif

   logic                clk   = 1'b0;
   logic                reset = 1'b1;
   logic [NREQ-1:0]     req   = '0;
   logic [NREQ*XW-1:0]  req_x;
   logic [NREQ*YW-1:0]  req_y;
   logic [NREQ*XW-1:0]  req_w;
   logic [NREQ*YW-1:0]  req_h;
   logic [CW-1:0]       pix_colour = '0;
   logic [NREQ-1:0]     gnt;
   logic [XW-1:0]       offs_x;
   logic [YW-1:0]       offs_y;
   logic [XW-1:0]       x;
   logic [YW-1:0]       y;
   logic [CW-1:0]       colour;
   logic                writeEn;
   logic [NREQ-1:0]     done;
   logic                busy;

   int gx [NREQ];
   int gy [NREQ];
   int gw [NREQ];
   int gh [NREQ];

   int nvec = 0;
   int nerr = 0;

   draw_port_arbiter #(
      .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW),
      .SCREEN_W(160), .SCREEN_H(120), .TRANSP_COLOUR(3'b000)
   ) dut (
      .clk(clk), .reset(reset), .req(req),
      .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
      .pix_colour(pix_colour), .gnt(gnt), .offs_x(offs_x), .offs_y(offs_y),
      .x(x), .y(y), .colour(colour), .writeEn(writeEn), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         req_x[k*XW +: XW] = XW'(gx[k]);
         req_y[k*YW +: YW] = YW'(gy[k]);
         req_w[k*XW +: XW] = XW'(gw[k]);
         req_h[k*YW +: YW] = YW'(gh[k]);
      end
   end

   // Requester colour ROM: synchronous, addressed by the offsets and grant.
   always @(posedge clk) begin
      pix_colour <= {offs_x[0], offs_y[0], gnt[1] | gnt[3]};
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: when idle and requests are present, the whole job's
   // cycle-by-cycle outputs are queued from its geometry.
   // ------------------------------------------------------------------------
   typedef struct {
      logic       busy;
      logic [3:0] gnt;
      logic [3:0] done;
      logic       chk_off;
      int         ox;
      int         oy;
      logic       wr;
      logic       we;
      int         x;
      int         y;
      int         col;
   } exp_t;

   exp_t q[$];
   int   m_rr = 0;

   function automatic exp_t blank();
      exp_t e;
      e.busy = 0; e.gnt = '0; e.done = '0; e.chk_off = 0; e.ox = 0; e.oy = 0;
      e.wr = 0; e.we = 0; e.x = 0; e.y = 0; e.col = 0;
      return e;
   endfunction

   function automatic int pix_col(input int ox, input int oy, input int w);
      return (ox % 2) * 4 + (oy % 2) * 2 + (w % 2);
   endfunction

   task automatic model_job(input logic [3:0] r);
      int win, n, w, h, p, pox, poy, ax, ay, idx;
      logic [3:0] oh;
      exp_t e;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_rr + k) % NREQ;
         if (win < 0 && r[idx]) win = idx;
      end
      oh = 4'(1 << win);
      w = gw[win]; h = gh[win]; n = w * h;
      e = blank(); e.busy = 1; e.gnt = oh;
      q.push_back(e);
      if (n > 0) begin
         for (int c = 0; c <= n; c++) begin
            e = blank(); e.busy = 1; e.gnt = oh;
            if (c < n) begin
               e.chk_off = 1; e.ox = c % w; e.oy = c / w;
            end
            if (c > 0) begin
               p = c - 1; pox = p % w; poy = p / w;
               ax = gx[win] + pox; ay = gy[win] + poy;
               e.wr = 1; e.x = ax % 256; e.y = ay % 128;
               e.col = pix_col(pox, poy, win);
               e.we = (ax < 160) && (ay < 120) && !(TR && e.col == 0);
            end
            q.push_back(e);
         end
      end
      e = blank(); e.busy = 1; e.done = oh;
      q.push_back(e);
      m_rr = (win + 1) % NREQ;
   endtask

   task automatic cmp(input exp_t e);
      chk("busy", busy, e.busy);
      chk("gnt", gnt, e.gnt);
      chk("done", done, e.done);
      chk("writeEn", writeEn, e.we);
      if (e.chk_off) begin
         chk("offs_x", offs_x, e.ox);
         chk("offs_y", offs_y, e.oy);
      end
      if (e.wr) begin
         chk("x", x, e.x);
         chk("y", y, e.y);
         chk("colour", colour, e.col);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         q.delete();
         m_rr = 0;
      end else if (q.size() == 0) begin
         e = blank();
         cmp(e);
         if (req != '0) model_job(req);
      end else begin
         e = q.pop_front();
         cmp(e);
      end
   end

   // ------------------------------------------------------------------------
   // Directed sequences with hand-computed expectations
   // ------------------------------------------------------------------------
   int   wx [64];
   int   wy [64];
   logic we_hist [128];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_offs_x"}, offs_x, 0);
      chk({tag, "_offs_y"}, offs_y, 0);
      chk({tag, "_x"}, x, 0);
      chk({tag, "_y"}, y, 0);
      chk({tag, "_colour"}, colour, 0);
      chk({tag, "_writeEn"}, writeEn, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Observe from the current cycle until done[didx] pulses (bounded).
   task automatic watch(input int didx, input int maxc, output int ncyc,
                        output int nbusy, output int nwr, output logic [3:0] g1);
      bit seen;
      seen = 0; ncyc = 0; nbusy = 0; nwr = 0; g1 = '0;
      for (int c = 0; c < maxc && !seen; c++) begin
         @(negedge clk);
         ncyc++;
         if (busy) nbusy++;
         if (g1 == '0) g1 = gnt;
         if (c < 128) we_hist[c] = writeEn;
         if (writeEn && nwr < 64) begin
            wx[nwr] = x; wy[nwr] = y; nwr++;
         end
         if (done[didx]) seen = 1;
      end
      chk($sformatf("done%0d_seen", didx), seen, 1);
      step();
   endtask

   initial begin
      int ncyc, nbusy, nwr, nd;
      logic [3:0] g1;
      int dseq [5];
      int exp_rr [5];
      int exp_cx [4];
      int exp_cy [4];
      logic [3:0] pat;
      exp_rr = '{0, 1, 2, 3, 0};
      exp_cx = '{158, 159, 158, 159};
      exp_cy = '{118, 118, 119, 119};
      for (int k = 0; k < NREQ; k++) begin
         gx[k] = 0; gy[k] = 0; gw[k] = 0; gh[k] = 0;
      end
      for (int k = 0; k < 5; k++) dseq[k] = -1;

      // reset state
      #8;
      check_zero("reset");
      #20 reset = 1'b0;
      step();

      // round robin, all requesters held, 1x1 jobs
      for (int k = 0; k < NREQ; k++) begin
         gx[k] = k * 10; gy[k] = k; gw[k] = 1; gh[k] = 1;
      end
      req = 4'b1111;
      nd = 0;
      for (int c = 0; c < 80 && nd < 5; c++) begin
         @(negedge clk);
         if (done != '0) begin
            for (int k = 0; k < NREQ; k++) if (done[k]) dseq[nd] = k;
            nd++;
         end
      end
      chk("rr_count", nd, 5);
      step();
      req = '0;
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), dseq[k], exp_rr[k]);

      // single 3x2 job at (10,20)
      gx[1] = 10; gy[1] = 20; gw[1] = 3; gh[1] = 2;
      req = 4'b0010;
      watch(1, 40, ncyc, nbusy, nwr, g1);
      req = '0;
      chk("single_gnt", g1, 4'b0010);
      chk("single_nwr", nwr, 6);
      chk("single_busy", nbusy, 9);
      chk("single_cycles", ncyc, 10);
      chk("single_w0x", wx[0], 10); chk("single_w0y", wy[0], 20);
      chk("single_w2x", wx[2], 12); chk("single_w2y", wy[2], 20);
      chk("single_w3x", wx[3], 10); chk("single_w3y", wy[3], 21);
      chk("single_w5x", wx[5], 12); chk("single_w5y", wy[5], 21);

      // clipping at the bottom-right corner
      gx[3] = 158; gy[3] = 118; gw[3] = 4; gh[3] = 4;
      req = 4'b1000;
      watch(3, 60, ncyc, nbusy, nwr, g1);
      req = '0;
      chk("clip_nwr", nwr, 4);
      chk("clip_cycles", ncyc, 20);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("clip_w%0dx", k), wx[k], exp_cx[k]);
         chk($sformatf("clip_w%0dy", k), wy[k], exp_cy[k]);
      end

      // empty job
      gx[2] = 30; gy[2] = 30; gw[2] = 0; gh[2] = 5;
      req = 4'b0100;
      watch(2, 20, ncyc, nbusy, nwr, g1);
      req = '0;
      chk("empty_nwr", nwr, 0);
      chk("empty_done_delay", ncyc - 1, 2);
      chk("empty_busy", nbusy, 2);

      // x carry-out wraps past the coordinate width: nothing written
      gx[0] = 250; gy[0] = 5; gw[0] = 8; gh[0] = 1;
      req = 4'b0001;
      watch(0, 30, ncyc, nbusy, nwr, g1);
      req = '0;
      chk("carry_nwr", nwr, 0);
      chk("carry_cycles", ncyc, 12);

      // alternating 000/100 colour over a 4x1 job
      gx[0] = 20; gy[0] = 30; gw[0] = 4; gh[0] = 1;
      req = 4'b0001;
      watch(0, 30, ncyc, nbusy, nwr, g1);
      req = '0;
      pat = {we_hist[3], we_hist[4], we_hist[5], we_hist[6]};
      chk("transp_pattern", pat, TR ? 4'b0101 : 4'b1111);

      // late arrival waits; winner drops req and geometry changes mid-job
      gx[1] = 40; gy[1] = 50; gw[1] = 2; gh[1] = 2;
      gx[0] = 0;  gy[0] = 0;  gw[0] = 1; gh[0] = 3;
      req = 4'b0010;
      step(); step(); step();
      req = 4'b0001;
      gx[1] = 99; gw[1] = 7;
      watch(1, 30, ncyc, nbusy, nwr, g1);
      watch(0, 30, ncyc, nbusy, nwr, g1);
      req = '0;
      chk("late_gnt", g1, 4'b0001);
      chk("late_nwr", nwr, 3);
      chk("late_w2y", wy[2], 2);

      // reset in the middle of a 10x10 job
      gx[2] = 5; gy[2] = 5; gw[2] = 10; gh[2] = 10;
      req = 4'b0100;
      for (int c = 0; c < 20; c++) step();
      #2 reset = 1'b1;
      #1 check_zero("midrst");
      req = '0;
      step(); step();
      #2 reset = 1'b0;
      step();
      req = 4'b0101;
      watch(0, 30, ncyc, nbusy, nwr, g1);
      req = '0;
      chk("postrst_gnt", g1, 4'b0001);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
